// File: rtl/multdiv_pkg.sv
// Shared types and default constants for the iterative multiply/divide
// sequencing controller.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int MULT_STEPS_DEF = 16;
  localparam int DIV_STEPS_DEF  = 32;

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiplier/divider.
// Latches the requested op, issues one datapath step per cycle for the
// op's iteration count, then registers the datapath result/exception and
// pulses data_resultRDY for one cycle. The iteration counter is external
// and restarted through counter_reset.
// Optional feature macro: MULTDIV_DIV0_CHECK_EN -- a divide whose divisor
// is zero skips the RUN phase and reports result 0 with exception set.
// Handshake: ctrl_MULT/ctrl_DIV are level starts sampled every cycle (no
// ready back-pressure; a start while busy aborts and restarts);
// data_resultRDY is a one-cycle valid pulse with no ready, and
// data_result/data_exception hold until the next completed op or reset.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_STEPS = MULT_STEPS_DEF,
  parameter int DIV_STEPS  = DIV_STEPS_DEF,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  input  logic [5:0]            count,
  input  logic                  divisor_zero,
  input  logic [DATA_WIDTH-1:0] dp_result,
  input  logic                  dp_exception,
  output logic                  counter_reset,
  output logic                  load,
  output logic                  step_mult,
  output logic                  step_div,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output state_e                dbg_state
);

  // Step counts must fit the 6-bit counter.
  if (MULT_STEPS < 1 || MULT_STEPS > 63) begin : g_bad_mult_steps
    $error("multdiv_ctrl: MULT_STEPS must be in 1..63");
  end
  if (DIV_STEPS < 1 || DIV_STEPS > 63) begin : g_bad_div_steps
    $error("multdiv_ctrl: DIV_STEPS must be in 1..63");
  end

  // Last count value of RUN for each op; count is compared zero-extended.
  localparam logic [5:0] MULT_LAST = 6'(MULT_STEPS - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_STEPS - 1);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  exc_q, exc_d;
  logic                  rdy_q, rdy_d;
  logic                  start;
  op_e                   start_op;
  logic [5:0]            last_count;

`ifdef MULTDIV_DIV0_CHECK_EN
  logic                  zero_q, zero_d;
`else
  logic                  unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero;
`endif

  // MULT wins when both starts are high in the same cycle.
  assign start      = ctrl_MULT | ctrl_DIV;
  assign start_op   = ctrl_MULT ? OP_MULT : OP_DIV;
  assign last_count = (op_q == OP_MULT) ? MULT_LAST : DIV_LAST;

  // Next-state, op latch, result capture and step/load decode.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    result_d      = result_q;
    exc_d         = exc_q;
    rdy_d         = 1'b0;
    load          = 1'b0;
    step_mult     = 1'b0;
    step_div      = 1'b0;
`ifdef MULTDIV_DIV0_CHECK_EN
    zero_d        = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          op_d    = start_op;
        end
      end
      LOAD: begin
        load = 1'b1;
        if (start) begin
          state_d = LOAD;
          op_d    = start_op;
        end else begin
          state_d = RUN;
`ifdef MULTDIV_DIV0_CHECK_EN
          zero_d  = 1'b0;
          if (op_q == OP_DIV && divisor_zero) begin
            state_d = DONE;
            zero_d  = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        step_mult = (op_q == OP_MULT);
        step_div  = (op_q == OP_DIV);
        if (start) begin
          state_d = LOAD;
          op_d    = start_op;
        end else if (count >= last_count) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          // Abort: no ready pulse, previous result registers kept.
          state_d = LOAD;
          op_d    = start_op;
        end else begin
          state_d  = IDLE;
          rdy_d    = 1'b1;
          result_d = dp_result;
          exc_d    = dp_exception;
`ifdef MULTDIV_DIV0_CHECK_EN
          if (zero_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, op and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef MULTDIV_DIV0_CHECK_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef MULTDIV_DIV0_CHECK_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign counter_reset  = (state_q != RUN);
  assign busy           = (state_q != IDLE);
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed scenarios plus random
// start/abort/reset traffic compared every cycle against a timeline model.
// Honours MULTDIV_DIV0_CHECK_EN the same way as the design.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  localparam int DW = 32;
  localparam int NM = 16;
  localparam int ND = 32;
`ifdef MULTDIV_DIV0_CHECK_EN
  localparam bit DIV0 = 1'b1;
`else
  localparam bit DIV0 = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ctrl_MULT = 1'b0;
  logic          ctrl_DIV = 1'b0;
  logic [5:0]    count;
  logic          divisor_zero = 1'b0;
  logic [DW-1:0] dp_result = '0;
  logic          dp_exception = 1'b0;
  logic          counter_reset, load, step_mult, step_div, busy;
  logic [DW-1:0] data_result;
  logic          data_exception, data_resultRDY;
  state_e        dbg_state;

  always #5 clock = ~clock;

  // External free-running iteration counter owned by the controller.
  logic [5:0] cnt = '0;
  always @(posedge clock) cnt <= counter_reset ? 6'd0 : cnt + 6'd1;
  assign count = cnt;

  multdiv_ctrl #(.MULT_STEPS(NM), .DIV_STEPS(ND), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .count(count), .divisor_zero(divisor_zero), .dp_result(dp_result),
    .dp_exception(dp_exception), .counter_reset(counter_reset), .load(load),
    .step_mult(step_mult), .step_div(step_div), .busy(busy),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An op is described by its age: cycles since the cycle its start was
  // sampled. Age 1 is the load cycle, ages 2..N+1 step, age N+2 finishes,
  // and the ready pulse shows one cycle later.
  bit            m_active = 1'b0;
  bit            m_is_div = 1'b0;
  bit            m_short  = 1'b0;
  int            m_age    = 0;
  bit            m_rdy    = 1'b0;
  logic [DW-1:0] m_res    = '0;
  bit            m_exc    = 1'b0;

  function automatic int steps_of(input bit is_div);
    return is_div ? ND : NM;
  endfunction

  // Advance the model over the upcoming edge using the inputs now applied.
  task automatic model_step();
    int done_age;
    m_rdy = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_short  = 1'b0;
      m_res    = '0;
      m_exc    = 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      m_active = 1'b1;
      m_is_div = !ctrl_MULT;
      m_short  = 1'b0;
      m_age    = 1;
    end else if (m_active) begin
      done_age = m_short ? 2 : steps_of(m_is_div) + 2;
      if (m_age == done_age) begin
        m_active = 1'b0;
        m_rdy    = 1'b1;
        m_res    = m_short ? '0 : dp_result;
        m_exc    = m_short ? 1'b1 : dp_exception;
      end else begin
        if (m_age == 1 && DIV0 && m_is_div && divisor_zero) m_short = 1'b1;
        m_age++;
      end
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_outputs();
    bit stepping;
    stepping = m_active && !m_short && m_age >= 2 && m_age <= steps_of(m_is_div) + 1;
    cmp("busy", busy, m_active);
    cmp("load", load, m_active && m_age == 1);
    cmp("step_mult", step_mult, stepping && !m_is_div);
    cmp("step_div", step_div, stepping && m_is_div);
    cmp("counter_reset", counter_reset, !stepping);
    cmp("data_resultRDY", data_resultRDY, m_rdy);
    cmp("data_result", data_result, m_res);
    cmp("data_exception", data_exception, m_exc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  // Starts are high for the cycle before the first tick; returns the cycle
  // offset of the ready pulse (0 if none within the budget) and step counts.
  task automatic wait_rdy(output int lat, output int ms, output int ds);
    lat = 0; ms = 0; ds = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 1) begin
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
      end
      if (step_mult) ms++;
      if (step_div) ds++;
      if (data_resultRDY) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input bit mult, input bit div, input bit dz,
                        input logic [DW-1:0] res, input bit exc,
                        input int exp_lat, input int exp_ms, input int exp_ds,
                        input logic [DW-1:0] exp_res, input bit exp_exc);
    int lat, ms, ds;
    ctrl_MULT = mult; ctrl_DIV = div; divisor_zero = dz;
    dp_result = res;  dp_exception = exc;
    wait_rdy(lat, ms, ds);
    cmp("latency", lat, exp_lat);
    cmp("mult_steps", ms, exp_ms);
    cmp("div_steps", ds, exp_ds);
    cmp("result_value", data_result, exp_res);
    cmp("exception_value", data_exception, exp_exc);
    tick();
    cmp("rdy_single_pulse", data_resultRDY, 1'b0);
    divisor_zero = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, ms, ds, r;
    bit hit;

    // Reset.
    reset = 1'b1;
    repeat (3) tick();
    cmp("reset_counter_reset", counter_reset, 1'b1);
    cmp("reset_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // Multiply: ready at T+19, 16 steps.
    run_op(1, 0, 0, 32'h0000_0F00, 0, 19, 16, 0, 32'h0000_0F00, 0);

    // Divide with exception: 32 steps, ready at T+35.
    run_op(0, 1, 0, 32'h1234_5678, 1, 35, 0, 32, 32'h1234_5678, 1);

    // Simultaneous start: multiply wins.
    run_op(1, 1, 0, 32'hCAFE_0001, 0, 19, 16, 0, 32'hCAFE_0001, 0);

    // Divide by zero.
    if (DIV0) run_op(0, 1, 1, 32'hDEAD_BEEF, 0, 3, 0, 0, 32'h0, 1);
    else      run_op(0, 1, 1, 32'hDEAD_BEEF, 0, 35, 0, 32, 32'hDEAD_BEEF, 0);

    // Restart: divide start during multiply RUN at count 5. Ready lands at
    // T+35 from the restart cycle, i.e. 34 cycles after its sampling edge.
    dp_result = 32'h0BAD_F00D; dp_exception = 1'b0;
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      tick();
      hit = step_mult && (count == 6'd5);
    end
    cmp("restart_reached_count5", hit, 1'b1);
    ctrl_DIV = 1'b1;
    wait_rdy(lat, ms, ds);
    cmp("restart_latency", lat, 35);
    cmp("restart_mult_steps", ms, 0);
    cmp("restart_div_steps", ds, 32);
    tick();

    // Reset mid-RUN at count 7.
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      tick();
      hit = step_mult && (count == 6'd7);
    end
    cmp("midrun_reached_count7", hit, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("midrun_busy", busy, 1'b0);
    cmp("midrun_counter_reset", counter_reset, 1'b1);
    cmp("midrun_step_mult", step_mult, 1'b0);
    cmp("midrun_rdy", data_resultRDY, 1'b0);
    cmp("midrun_result_cleared", data_result, 32'h0);
    tick();

    // Random traffic: starts, aborts, zero divisors, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 199);
      ctrl_MULT    = (r < 2) || (r == 4);
      ctrl_DIV     = (r >= 2 && r < 5);
      divisor_zero = ($urandom_range(0, 3) == 0);
      dp_result    = $urandom;
      dp_exception = $urandom_range(0, 1);
      reset        = ($urandom_range(0, 599) == 0);
      tick();
    end
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; reset = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller for the iterative multiplier/divider. Consumes the 6-bit iteration count from the free-running multdiv counter and owns that counter's reset. Latches the requested operation, issues one datapath step per cycle for the configured number of iterations, then registers the datapath result and exception and publishes them with a one-cycle ready pulse.

## Interface
- MULT_STEPS, 16: Booth radix-4 multiply iterations; 1..63.
- DIV_STEPS, 32: non-restoring divide iterations; 1..63.
- DATA_WIDTH, 32: result width.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- ctrl_MULT  in  1  start multiply; sampled every cycle.
- ctrl_DIV  in  1  start divide; sampled every cycle.
- count  in  6  iteration count from counter; 0 in the cycle after counter_reset is high, then +1 per cycle.
- divisor_zero  in  1  datapath flag: latched divisor is zero.
- dp_result  in  DATA_WIDTH  datapath result.
- dp_exception  in  1  datapath exception (overflow / div-by-zero).
- counter_reset  out  1  restart iteration counter.
- load  out  1  datapath latches operands this cycle.
- step_mult  out  1  advance multiply datapath one iteration.
- step_div  out  1  advance divide datapath one iteration.
- busy  out  1  operation in progress.
- data_result  out  DATA_WIDTH  registered result.
- data_exception  out  1  registered exception.
- data_resultRDY  out  1  one-cycle pulse; result and exception valid.

## Operation
- States: IDLE, LOAD, RUN, DONE. Op register: MULT or DIV.
- IDLE: ctrl_MULT or ctrl_DIV high -> LOAD, op latched. Both high -> MULT wins.
- LOAD: load=1 -> RUN.
- RUN: step_mult (op MULT) or step_div (op DIV) high every cycle. Let N be the op's step count. Leave for DONE at the edge where count >= N-1, so exactly N steps for counts 0..N-1; >= guards against overrun.
- DONE: no step. At the exit edge: data_result<=dp_result, data_exception<=dp_exception, data_resultRDY<=1. Then -> IDLE.
- data_resultRDY is high for exactly one cycle. data_result and data_exception hold until the next DONE exit or reset.
- counter_reset = (state != RUN), combinational.
- busy = (state != IDLE).
- load, step_mult and step_div are combinational from state and op.
- A start in LOAD, RUN or DONE aborts the current op and goes to LOAD with the new op latched. The aborted op never pulses data_resultRDY; old result registers are retained.
- Width rule: count is compared zero-extended against N-1 as a 6-bit constant. Parameters above 63 are illegal, checked by elaboration assertion.
- Reset: state IDLE, op MULT, data_result=0, data_exception=0, data_resultRDY=0, busy=0, load=0, step_mult=0, step_div=0, counter_reset=1.

## Timing
- Start sampled at edge T, i.e. high in cycle T.
- LOAD occupies cycle T+1.
- RUN occupies T+2..T+1+N.
- DONE occupies T+2+N.
- data_resultRDY is high in T+3+N: multiply T+19, divide T+35 at defaults.
- A start in the data_resultRDY cycle is a normal IDLE start; no gap cycle is required.

## Configuration
- MULTDIV_DIV0_CHECK_EN defined: in LOAD with op DIV and divisor_zero=1, go LOAD -> DONE with no RUN steps. The DONE exit captures data_result=0 and data_exception=1, ignoring dp_*. data_resultRDY appears at T+3.
- Undefined: divisor_zero is ignored. A zero-divisor divide runs all DIV_STEPS and reports dp_exception/dp_result.

## Structure
- Shared package multdiv_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE}
  - op enum {OP_MULT, OP_DIV}
  - default step constants MULT_STEPS_DEF=16, DIV_STEPS_DEF=32
- No sub-module. The FSM, op register and result registers sit in one module. The counter stays external and is driven via counter_reset.

## Test plan
- Reset mid-RUN: assert reset at count=7 -> next cycle IDLE, all outputs at reset values, counter_reset=1, no data_resultRDY.
- Multiply: ctrl_MULT at T, dp_result=0x0000_0F00, dp_exception=0 -> load at T+1; step_mult for exactly 16 cycles T+2..T+17; data_resultRDY single pulse at T+19 with data_result=0x0000_0F00.
- Divide with exception: ctrl_DIV at T, dp_exception=1 -> 32 step_div pulses; data_resultRDY at T+35 with data_exception=1.
- Simultaneous start: ctrl_MULT=ctrl_DIV=1 at T -> only step_mult asserted; data_resultRDY at T+19.
- Restart: ctrl_DIV at RUN count=5 of a multiply -> LOAD next cycle, no data_resultRDY for the multiply, 32 step_div pulses, data_resultRDY 34 cycles after the restart edge.
- Divide by zero, divisor_zero=1:
  - Macro defined: data_resultRDY at T+3, data_result=0, data_exception=1, zero step_div.
  - Macro undefined: data_resultRDY at T+35.
